mips_exec_unit: RTL and testbench

MIPS_EXEC_UNIT -- requirements
Module: mips_exec_unit

---
 rtl/mips_exec_unit.sv | 134 +++++++++++++
 tb/tb_mips_exec_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_unit.sv
// rtl/mips_exec_unit.sv - MIPS execute stage: ALU control decode, ALU, branch target, one-cycle registered result
module mips_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       alu_op,
    input  logic [5:0]       func,
    input  logic [4:0]       branchz_func,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc,
    input  logic [15:0]      imm,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] branch_target,
    output logic [4:0]       alu_ctrl
);
    localparam logic [4:0] C_AND = 5'd0, C_OR = 5'd1, C_ADD = 5'd2, C_XOR = 5'd3,
                           C_SLL = 5'd4, C_SRL = 5'd5, C_SRA = 5'd6, C_SUB = 5'd7,
                           C_SLT = 5'd8, C_SLTU = 5'd9, C_NOR = 5'd10, C_SLLV = 5'd11,
                           C_SRLV = 5'd12, C_SRAV = 5'd13, C_BNE = 5'd14, C_BLTZ = 5'd15,
                           C_BGEZ = 5'd16, C_BLEZ = 5'd17, C_BGTZ = 5'd18;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q;
    logic [WIDTH-1:0] branch_target_q, branch_target_d;
    logic [4:0]       alu_ctrl_q, alu_ctrl_d;
    logic             a_neg, a_is_zero, taken;
    logic             unused_bz;

    // Only the low REGIMM bit separates BLTZ from BGEZ.
    assign unused_bz = ^branchz_func[4:1];
    assign a_neg     = a[WIDTH-1];
    assign a_is_zero = (a == '0);

    always_comb begin
        alu_ctrl_d = C_ADD;
        unique case (alu_op)
            4'd0:    alu_ctrl_d = C_ADD;
            4'd1:    alu_ctrl_d = C_SUB;
            4'd2: begin
                case (func)
                    6'h00:        alu_ctrl_d = C_SLL;
                    6'h02:        alu_ctrl_d = C_SRL;
                    6'h03:        alu_ctrl_d = C_SRA;
                    6'h04:        alu_ctrl_d = C_SLLV;
                    6'h06:        alu_ctrl_d = C_SRLV;
                    6'h07:        alu_ctrl_d = C_SRAV;
                    6'h22, 6'h23: alu_ctrl_d = C_SUB;
                    6'h24:        alu_ctrl_d = C_AND;
                    6'h25:        alu_ctrl_d = C_OR;
                    6'h26:        alu_ctrl_d = C_XOR;
                    6'h27:        alu_ctrl_d = C_NOR;
                    6'h2A:        alu_ctrl_d = C_SLT;
                    6'h2B:        alu_ctrl_d = C_SLTU;
                    default:      alu_ctrl_d = C_ADD;
                endcase
            end
            4'd3:    alu_ctrl_d = C_AND;
            4'd4:    alu_ctrl_d = C_OR;
            4'd5:    alu_ctrl_d = C_XOR;
            4'd6:    alu_ctrl_d = C_SLT;
            4'd7:    alu_ctrl_d = C_SLTU;
            4'd8:    alu_ctrl_d = branchz_func[0] ? C_BGEZ : C_BLTZ;
            4'd9:    alu_ctrl_d = C_BNE;
            4'd10:   alu_ctrl_d = C_BLEZ;
            4'd11:   alu_ctrl_d = C_BGTZ;
            default: alu_ctrl_d = C_ADD;
        endcase
    end

    always_comb begin
        result_d = '0;
        taken    = 1'b0;
        case (alu_ctrl_d)
            C_AND:  result_d = a & b;
            C_OR:   result_d = a | b;
            C_XOR:  result_d = a ^ b;
            C_NOR:  result_d = ~(a | b);
            C_SUB:  result_d = a - b;
            C_SLL:  result_d = b << shamt;
            C_SRL:  result_d = b >> shamt;
            C_SRA:  result_d = $signed(b) >>> shamt;
            C_SLLV: result_d = b << a[4:0];
            C_SRLV: result_d = b >> a[4:0];
            C_SRAV: result_d = $signed(b) >>> a[4:0];
            C_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            C_SLTU: result_d = {{(WIDTH-1){1'b0}}, (a < b)};
            C_BNE, C_BLTZ, C_BGEZ, C_BLEZ, C_BGTZ: begin
                // Branch codes report "taken" as a zero result.
                case (alu_ctrl_d)
                    C_BNE:   taken = (a != b);
                    C_BLTZ:  taken = a_neg;
                    C_BGEZ:  taken = !a_neg;
                    C_BLEZ:  taken = a_neg || a_is_zero;
                    default: taken = !a_neg && !a_is_zero;
                endcase
                result_d = {{(WIDTH-1){1'b0}}, !taken};
            end
            default: result_d = a + b;
        endcase
    end

    assign branch_target_d = pc + WIDTH'(4) + ({{(WIDTH-16){imm[15]}}, imm} << 2);

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q     <= 1'b0;
            result_q        <= '0;
            zero_q          <= 1'b0;
            branch_target_q <= '0;
            alu_ctrl_q      <= '0;
        end else if (in_valid) begin
            out_valid_q     <= 1'b1;
            result_q        <= result_d;
            zero_q          <= (result_d == '0);
            branch_target_q <= branch_target_d;
            alu_ctrl_q      <= alu_ctrl_d;
        end else begin
            out_valid_q     <= 1'b0;
        end
    end

    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign zero          = zero_q;
    assign branch_target = branch_target_q;
    assign alu_ctrl      = alu_ctrl_q;
endmodule

// File: tb/tb_mips_exec_unit.sv
// tb/tb_mips_exec_unit.sv - scoreboard bench for mips_exec_unit with a behavioural reference model
module tb_mips_exec_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  alu_op;
    logic [5:0]  func;
    logic [4:0]  branchz_func;
    logic [4:0]  shamt;
    logic [31:0] a, b, pc;
    logic [15:0] imm;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic [31:0] branch_target;
    logic [4:0]  alu_ctrl;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic [31:0] bt;
        logic [4:0]  c;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;
    int   tests = 0;
    int   fails = 0;
    logic rst_s = 1'b0;
    logic started = 1'b0;

    mips_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op), .func(func),
        .branchz_func(branchz_func), .shamt(shamt), .a(a), .b(b), .pc(pc), .imm(imm),
        .out_valid(out_valid), .result(result), .zero(zero),
        .branch_target(branch_target), .alu_ctrl(alu_ctrl)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] bz,
                                   input logic [4:0] sh, input logic [31:0] av, input logic [31:0] bv,
                                   input logic [31:0] pcv, input logic [15:0] iv);
        exp_t e;
        int code;
        int sa, sb;
        logic signed [31:0] off;
        sa = $signed(av);
        sb = $signed(bv);
        case (op)
            1: code = 7;
            2: case (fn)
                   6'h00: code = 4;   6'h02: code = 5;   6'h03: code = 6;
                   6'h04: code = 11;  6'h06: code = 12;  6'h07: code = 13;
                   6'h22, 6'h23: code = 7;
                   6'h24: code = 0;   6'h25: code = 1;   6'h26: code = 3;
                   6'h27: code = 10;  6'h2A: code = 8;   6'h2B: code = 9;
                   default: code = 2;
               endcase
            3: code = 0;  4: code = 1;  5: code = 3;  6: code = 8;  7: code = 9;
            8: code = bz[0] ? 16 : 15;
            9: code = 14; 10: code = 17; 11: code = 18;
            default: code = 2;
        endcase
        case (code)
            0:  e.r = av & bv;
            1:  e.r = av | bv;
            3:  e.r = av ^ bv;
            10: e.r = ~(av | bv);
            7:  e.r = av - bv;
            4:  e.r = bv << sh;
            5:  e.r = bv >> sh;
            6:  e.r = sb >>> sh;
            11: e.r = bv << (av % 32);
            12: e.r = bv >> (av % 32);
            13: e.r = sb >>> (av % 32);
            8:  e.r = (sa < sb) ? 1 : 0;
            9:  e.r = (av < bv) ? 1 : 0;
            14: e.r = (av != bv) ? 0 : 1;
            15: e.r = (sa < 0) ? 0 : 1;
            16: e.r = (sa >= 0) ? 0 : 1;
            17: e.r = (sa <= 0) ? 0 : 1;
            18: e.r = (sa > 0) ? 0 : 1;
            default: e.r = av + bv;
        endcase
        e.z  = (e.r == 0);
        off  = $signed(iv);
        e.bt = pcv + 32'd4 + off * 4;
        e.c  = 5'(code);
        return e;
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] fn, input logic [4:0] bz,
                         input logic [4:0] sh, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] pcv, input logic [15:0] iv);
        in_valid = v; alu_op = op; func = fn; branchz_func = bz; shamt = sh;
        a = av; b = bv; pc = pcv; imm = iv;
        if (v && reset) exp_q.push_back(model(op, fn, bz, sh, av, bv, pcv, iv));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input exp_t want);
        exp_t got;
        got = '{r: result, z: zero, bt: branch_target, c: alu_ctrl};
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got result=%h zero=%b bt=%h ctrl=%0d, want result=%h zero=%b bt=%h ctrl=%0d",
                     name, got.r, got.z, got.bt, got.c, want.r, want.z, want.bt, want.c);
        end
    endtask

    always @(posedge clk) begin
        rst_s   <= reset;
        started <= 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            if (!rst_s) begin
                held = '0;
                tests++;
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_valid: got %b want 0", out_valid);
                end
                check("reset_outputs", held);
            end else if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got out_valid=1 want 0 (no pending op)");
                end else begin
                    held = exp_q.pop_front();
                    check("result", held);
                end
            end else begin
                tests++;
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL valid_x: got %b want 0", out_valid);
                end
                check("hold", held);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        drive(1, 4'd0, 6'h20, 5'd0, 5'd0, 32'h1, 32'h1, 32'h100, 16'h1);
        drive(1, 4'd0, 6'h20, 5'd0, 5'd0, 32'h1, 32'h1, 32'h100, 16'h1);
        reset = 1'b1;
        drive(0, 4'd0, 6'h20, 5'd0, 5'd0, 32'h1, 32'h1, 32'h100, 16'h1);
        drive(1, 4'd2, 6'h21, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 16'h0);
        drive(1, 4'd2, 6'h03, 5'd0, 5'd4, 32'h0, 32'h8000_0000, 32'h0, 16'h0);
        drive(1, 4'd2, 6'h06, 5'd0, 5'd0, 32'h24, 32'h8000_0000, 32'h0, 16'h0);
        drive(1, 4'd6, 6'h00, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 16'h0);
        drive(1, 4'd7, 6'h00, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 16'h0);
        drive(1, 4'd8, 6'h00, 5'd1, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0);
        drive(1, 4'd8, 6'h00, 5'd1, 5'd0, 32'h8000_0000, 32'h0, 32'h0, 16'h0);
        drive(1, 4'd8, 6'h00, 5'd0, 5'd0, 32'h8000_0000, 32'h0, 32'h0, 16'h0);
        drive(1, 4'd11, 6'h00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0);
        drive(1, 4'd10, 6'h00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0);
        drive(1, 4'd9, 6'h00, 5'd0, 5'd0, 32'h5, 32'h6, 32'h0, 16'h0);
        drive(1, 4'd1, 6'h00, 5'd0, 5'd0, 32'h7, 32'h7, 32'hBFC0_0000, 16'hFFFF);
        drive(1, 4'd0, 6'h00, 5'd0, 5'd0, 32'h3, 32'h4, 32'hBFC0_0000, 16'h0004);
        drive(0, 4'd0, 6'h00, 5'd0, 5'd0, 32'h9, 32'h9, 32'h0, 16'h0);
        drive(0, 4'd3, 6'h00, 5'd0, 5'd0, 32'h9, 32'h9, 32'h0, 16'h0);
        for (int i = 0; i < 400; i++) begin
            logic [5:0] fn;
            logic [5:0] legal [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                       6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal[$urandom_range(0, 15)];
            drive(($urandom_range(0, 3) != 0), 4'($urandom), fn, 5'($urandom), 5'($urandom),
                  rnd_word(), rnd_word(), $urandom, 16'($urandom));
        end
        reset = 1'b0;
        drive(1, 4'd0, 6'h20, 5'd0, 5'd0, 32'h1, 32'h1, 32'h40, 16'h2);
        reset = 1'b1;
        drive(0, 4'd0, 6'h20, 5'd0, 5'd0, 32'h1, 32'h1, 32'h40, 16'h2);
        drive(0, 4'd5, 6'h20, 5'd0, 5'd0, 32'h2, 32'h3, 32'h40, 16'h2);
        drive(1, 4'd5, 6'h20, 5'd0, 5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h1000, 16'h8000);
        drive(0, 4'd0, 6'h20, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0);
        drive(0, 4'd0, 6'h20, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0);
        @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
